// File: rtl/axi_interconnect_rd.sv
// AXI read master for audio playback.
// Replays the recorded DDR region [read pointer, record_end_addr) in fixed
// BURST_LEN bursts and streams every returned beat into the playback FIFO.
// Only whole bursts are read; the address step matches the recording writer.
module axi_interconnect_rd #(
    parameter int MEM_ROW_WIDTH    = 15,
    parameter int MEM_COLUMN_WIDTH = 10,
    parameter int MEM_BANK_WIDTH   = 3,
    parameter int CTRL_ADDR_WIDTH  = MEM_ROW_WIDTH + MEM_BANK_WIDTH + MEM_COLUMN_WIDTH,
    parameter int DQ_WIDTH         = 32,
    parameter int BURST_LEN        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rs232_data,
    input  logic                       rs232_flag,
    input  logic [CTRL_ADDR_WIDTH-1:0] record_end_addr,
    input  logic                       channel1_wready,
    output logic                       channel1_wr_en,
    output logic [DQ_WIDTH*8-1:0]      channel1_data,
    output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
    output logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [DQ_WIDTH*8-1:0]      axi_rdata,
    input  logic                       axi_rvalid,
    input  logic                       axi_rlast,
    output logic                       play_valid,
    output logic                       play_done,
    output logic                       rd_err
);

    localparam int ADDR_STEP = BURST_LEN * 8;
    localparam int CNT_W     = $clog2(BURST_LEN) + 1;

    // Step widened by one bit so the end-of-data compare cannot wrap.
    localparam logic [CTRL_ADDR_WIDTH:0] STEP_WIDE = (CTRL_ADDR_WIDTH + 1)'(ADDR_STEP);
    localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'b001,
        AXI_ARADDR = 3'b010,
        AXI_RDATA  = 3'b100
    } state_t;

    state_t                     state;
    logic                       wready_meta;
    logic                       wready_s;
    logic [CNT_W-1:0]           beat_cnt;
    logic                       rewind_pend;

    logic                       cmd_play;
    logic                       cmd_stop;
    logic                       cmd_rewind;
    logic [CTRL_ADDR_WIDTH:0]   burst_end;
    logic                       data_left;

    assign cmd_play   = rs232_flag && (rs232_data == 8'hA3);
    assign cmd_stop   = rs232_flag && (rs232_data == 8'hA4);
    assign cmd_rewind = rs232_flag && (rs232_data == 8'hA0);

    // A full burst fits when its end does not pass the recorder's write pointer.
    assign burst_end = {1'b0, axi_araddr} + STEP_WIDE;
    assign data_left = (burst_end <= {1'b0, record_end_addr});

    // Beats go straight to the FIFO; the FIFO readiness check is done before the AR.
    assign channel1_wr_en = (state == AXI_RDATA) && axi_rvalid;
    assign channel1_data  = axi_rdata;

    // Two-flop synchronizer for the FIFO-side ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wready_meta <= 1'b0;
            wready_s    <= 1'b0;
        end else begin
            wready_meta <= channel1_wready;
            wready_s    <= wready_meta;
        end
    end

    // Command decode plus burst FSM with registered AR outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            play_valid  <= 1'b0;
            play_done   <= 1'b0;
            rd_err      <= 1'b0;
            beat_cnt    <= '0;
            rewind_pend <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees the
            // values from the previous cycle regardless of statement order;
            // a later assignment to the same register overrides an earlier one.
            play_done <= 1'b0;

            if (cmd_play) begin
                play_valid <= 1'b1;
            end else if (cmd_stop) begin
                play_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_rewind) begin
                        // Rewind wins this cycle; issue is re-evaluated from address 0.
                        axi_araddr <= '0;
                    end else if (play_valid && !data_left) begin
                        play_valid <= 1'b0;
                        play_done  <= 1'b1;
                    end else if (play_valid && wready_s) begin
                        axi_arvalid <= 1'b1;
                        state       <= AXI_ARADDR;
                    end
                end

                AXI_ARADDR: begin
                    // The pending address must stay stable, so a rewind is deferred.
                    if (cmd_rewind) begin
                        rewind_pend <= 1'b1;
                    end
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_araddr  <= (cmd_rewind || rewind_pend) ? '0
                                     : axi_araddr + STEP_WIDE[CTRL_ADDR_WIDTH-1:0];
                        rewind_pend <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= AXI_RDATA;
                    end
                end

                AXI_RDATA: begin
                    if (cmd_rewind) begin
                        axi_araddr <= '0;
                    end
                    if (axi_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (axi_rlast) begin
                            state <= IDLE;
                            if (beat_cnt != LAST_BEAT) begin
                                rd_err <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    axi_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_interconnect_rd.sv
// Self-checking bench for axi_interconnect_rd.
// A behavioural AXI slave answers each accepted AR with random beats and pushes
// them to a scoreboard; a monitor pops and compares every FIFO write.
module tb_axi_interconnect_rd;

    localparam int AW = 28;
    localparam int DW = 256;

    logic          clk;
    logic          rst;
    logic [7:0]    rs232_data;
    logic          rs232_flag;
    logic [AW-1:0] record_end_addr;
    logic          channel1_wready;
    logic          channel1_wr_en;
    logic [DW-1:0] channel1_data;
    logic [AW-1:0] axi_araddr;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic          axi_rvalid;
    logic          axi_rlast;
    logic          play_valid;
    logic          play_done;
    logic          rd_err;

    axi_interconnect_rd dut (
        .clk             (clk),
        .rst             (rst),
        .rs232_data      (rs232_data),
        .rs232_flag      (rs232_flag),
        .record_end_addr (record_end_addr),
        .channel1_wready (channel1_wready),
        .channel1_wr_en  (channel1_wr_en),
        .channel1_data   (channel1_data),
        .axi_araddr      (axi_araddr),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .axi_rdata       (axi_rdata),
        .axi_rvalid      (axi_rvalid),
        .axi_rlast       (axi_rlast),
        .play_valid      (play_valid),
        .play_done       (play_done),
        .rd_err          (rd_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];

    int beats_per_burst = 16;
    int ar_cnt          = 0;
    bit slave_busy      = 0;
    int wr_cnt          = 0;
    int done_cnt        = 0;
    int arv_cnt         = 0;
    logic [DW-1:0] slv_data;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // AXI slave model: answers every accepted AR with beats_per_burst beats.
    initial begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst && axi_arvalid && axi_arready) begin
                ar_cnt++;
                if (exp_addr_q.size() == 0)
                    check("ar_queue_nonempty", exp_addr_q.size(), 1);
                else
                    check("ar_addr", axi_araddr, exp_addr_q.pop_front());
                slave_busy = 1;
                @(posedge clk);
                #1;
                for (int b = 0; b < beats_per_burst; b++) begin
                    slv_data   = rand_data();
                    axi_rdata  = slv_data;
                    axi_rvalid = 1'b1;
                    axi_rlast  = (b == beats_per_burst - 1);
                    exp_data_q.push_back(slv_data);
                    @(posedge clk);
                    #1;
                end
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
                slave_busy = 0;
            end
        end
    end

    // Output monitor: scoreboard compare of FIFO writes, event counters.
    initial begin
        forever begin
            @(negedge clk);
            if (axi_arvalid) arv_cnt++;
            if (play_done) done_cnt++;
            if (channel1_wr_en) begin
                wr_cnt++;
                if (exp_data_q.size() == 0)
                    check("wr_queue_nonempty", exp_data_q.size(), 1);
                else
                    check("fifo_data", channel1_data, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1;
        rs232_data = b;
        rs232_flag = 1'b1;
        @(posedge clk);
        #1;
        rs232_flag = 1'b0;
        rs232_data = 8'h00;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        rs232_flag  = 1'b0;
        rs232_data  = 8'h00;
        axi_arready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(input int base, input int n, input string tag);
        int t = 0;
        while ((wr_cnt - base < n) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_wr_timeout"}, (wr_cnt - base < n), 0);
    endtask

    task automatic wait_done(input int base, input string tag);
        int t = 0;
        while ((done_cnt == base) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_timeout"}, (done_cnt == base), 0);
    endtask

    task automatic wait_slave_idle(input string tag);
        int t = 0;
        @(negedge clk);
        while ((slave_busy || axi_arvalid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle_timeout"}, (slave_busy || axi_arvalid), 0);
    endtask

    initial begin
        int w0, a0, d0, v0, lat, bad, t;

        rst             = 1'b1;
        rs232_flag      = 1'b0;
        rs232_data      = 8'h00;
        record_end_addr = AW'(512);
        channel1_wready = 1'b1;
        axi_arready     = 1'b0;

        // ---- Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_araddr", axi_araddr, 0);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_play_valid", play_valid, 0);
        check("rst_play_done", play_done, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_wr_en", channel1_wr_en, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---- 1: four back-to-back bursts, then end of data
        axi_arready = 1'b1;
        exp_addr_q.push_back(AW'(0));
        exp_addr_q.push_back(AW'(128));
        exp_addr_q.push_back(AW'(256));
        exp_addr_q.push_back(AW'(384));
        w0 = wr_cnt; a0 = ar_cnt; d0 = done_cnt;
        send_cmd(8'hA3);
        wait_done(d0, "t1");
        repeat (3) @(negedge clk);
        check("t1_ar_count", ar_cnt - a0, 4);
        check("t1_beats", wr_cnt - w0, 64);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_play_valid", play_valid, 0);
        check("t1_araddr", axi_araddr, 512);
        check("t1_data_q_empty", exp_data_q.size(), 0);
        check("t1_addr_q_empty", exp_addr_q.size(), 0);

        // ---- 2: FIFO not ready blocks issue; ready goes through the synchronizer
        channel1_wready = 1'b0;
        record_end_addr = AW'(128);
        do_reset();
        axi_arready = 1'b1;
        exp_addr_q.push_back(AW'(0));
        w0 = wr_cnt; v0 = arv_cnt; d0 = done_cnt;
        send_cmd(8'hA3);
        repeat (20) @(posedge clk);
        check("t2_no_arvalid", arv_cnt - v0, 0);
        #1;
        channel1_wready = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (axi_arvalid) begin
                lat = i;
                break;
            end
        end
        check("t2_ready_latency", lat, 4);
        wait_done(d0, "t2");
        check("t2_beats", wr_cnt - w0, 16);
        check("t2_play_valid", play_valid, 0);

        // ---- 3: stop mid-burst, remaining beats still written
        record_end_addr = AW'(1024);
        do_reset();
        axi_arready = 1'b1;
        exp_addr_q.push_back(AW'(0));
        w0 = wr_cnt; a0 = ar_cnt;
        send_cmd(8'hA3);
        wait_wr(w0, 5, "t3");
        send_cmd(8'hA4);
        check("t3_play_cleared", play_valid, 0);
        wait_slave_idle("t3");
        repeat (30) @(negedge clk);
        check("t3_ar_count", ar_cnt - a0, 1);
        check("t3_beats", wr_cnt - w0, 16);
        check("t3_arvalid_idle", axi_arvalid, 0);

        // ---- 4: rewind while AR is pending and not accepted
        do_reset();
        axi_arready = 1'b1;
        exp_addr_q.push_back(AW'(0));
        exp_addr_q.push_back(AW'(128));
        exp_addr_q.push_back(AW'(0));
        w0 = wr_cnt; a0 = ar_cnt;
        send_cmd(8'hA3);
        wait_wr(w0, 1, "t4");
        @(posedge clk);
        #1;
        axi_arready = 1'b0;
        t = 0;
        while (!axi_arvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_arvalid_timeout", axi_arvalid, 1);
        check("t4_pending_addr", axi_araddr, 128);
        send_cmd(8'hA0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (axi_araddr !== AW'(128) || axi_arvalid !== 1'b1) bad++;
        end
        check("t4_addr_hold", bad, 0);
        @(posedge clk);
        #1;
        axi_arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_rewound_addr", axi_araddr, 0);
        check("t4_arvalid_drop", axi_arvalid, 0);
        t = 0;
        while ((ar_cnt - a0 < 3) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_third_ar_timeout", (ar_cnt - a0 < 3), 0);
        send_cmd(8'hA4);
        wait_slave_idle("t4");
        repeat (5) @(negedge clk);
        check("t4_ar_count", ar_cnt - a0, 3);
        check("t4_araddr_after", axi_araddr, 128);
        check("t4_data_q_empty", exp_data_q.size(), 0);
        check("t4_addr_q_empty", exp_addr_q.size(), 0);

        // ---- 5a: too little recorded data ends playback immediately
        record_end_addr = AW'(100);
        do_reset();
        axi_arready = 1'b1;
        v0 = arv_cnt; d0 = done_cnt;
        send_cmd(8'hA3);
        check("t5_play_set", play_valid, 1);
        @(negedge clk);
        check("t5_done_not_yet", play_done, 0);
        @(negedge clk);
        check("t5_done_pulse", play_done, 1);
        check("t5_play_cleared", play_valid, 0);
        repeat (5) @(negedge clk);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_no_arvalid", arv_cnt - v0, 0);

        // ---- 5b: short burst (rlast on beat 8) flags a sticky error
        record_end_addr = AW'(128);
        beats_per_burst = 8;
        exp_addr_q.push_back(AW'(0));
        w0 = wr_cnt; d0 = done_cnt;
        check("t5_rd_err_before", rd_err, 0);
        send_cmd(8'hA3);
        wait_done(d0, "t5b");
        check("t5_short_beats", wr_cnt - w0, 8);
        check("t5_rd_err_set", rd_err, 1);
        repeat (10) @(negedge clk);
        check("t5_rd_err_sticky", rd_err, 1);
        beats_per_burst = 16;

        // ---- 6: asynchronous reset in the middle of a burst
        record_end_addr = AW'(1024);
        do_reset();
        axi_arready = 1'b1;
        exp_addr_q.push_back(AW'(0));
        w0 = wr_cnt;
        send_cmd(8'hA3);
        wait_wr(w0, 3, "t6");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_araddr", axi_araddr, 0);
        check("t6_arvalid", axi_arvalid, 0);
        check("t6_play_valid", play_valid, 0);
        check("t6_play_done", play_done, 0);
        check("t6_rd_err", rd_err, 0);
        check("t6_wr_en_in_reset", channel1_wr_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        while (slave_busy && t < 40) begin
            @(negedge clk);
            if (axi_rvalid) check("t6_stray_wr_en", channel1_wr_en, 0);
            t++;
        end
        check("t6_slave_timeout", slave_busy, 0);
        exp_data_q.delete();
        repeat (5) @(negedge clk);
        check("t6_no_new_ar", axi_arvalid, 0);
        check("t6_addr_q_empty", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_interconnect_rd.md
Name: axi_interconnect_rd

Overview:
AXI read master for audio playback. On an RS232 "play" command it reads the recorded region of DDR, starting at the read pointer and ending at the recorder's current write address, in fixed BURST_LEN bursts. It streams each beat into the playback FIFO (channel 1). It is the read-side counterpart of the recording write master and uses the same address step, so recorded bursts are replayed 1:1.

Parameters:
MEM_ROW_WIDTH, 15, DDR row address bits
MEM_COLUMN_WIDTH, 10, DDR column address bits
MEM_BANK_WIDTH, 3, DDR bank address bits
CTRL_ADDR_WIDTH, ROW+BANK+COLUMN, AXI address width
DQ_WIDTH, 32, DDR DQ width; data bus = DQ_WIDTH*8
BURST_LEN, 16, beats per read burst; addr_step = BURST_LEN*8

Ports:
clk  in  1  DDR core clock
rst  in  1  asynchronous reset, active-high
rs232_data  in  8  command byte
rs232_flag  in  1  command byte valid strobe
record_end_addr  in  CTRL_ADDR_WIDTH  recorder's next write address (end of valid audio), clk domain
channel1_wready  in  1  playback FIFO can accept a full burst (other clock domain)
channel1_wr_en  out  1  FIFO write strobe
channel1_data  out  DQ_WIDTH*8  FIFO write data
axi_araddr  out  CTRL_ADDR_WIDTH  read address (registered)
axi_arvalid  out  1  read address valid (registered)
axi_arready  in  1  address accepted
axi_rdata  in  DQ_WIDTH*8  read data
axi_rvalid  in  1  read data beat valid
axi_rlast  in  1  last beat of burst
play_valid  out  1  playback active
play_done  out  1  one-cycle pulse: end of recorded data reached
rd_err  out  1  sticky: burst beat count mismatch

Behaviour:
- Reset (async, rst=1): state IDLE; axi_araddr=0, axi_arvalid=0, play_valid=0, play_done=0, rd_err=0, beat_cnt=0, sync flops=0.
- Commands are decoded only when rs232_flag=1:
  - 0xA3 sets play_valid.
  - 0xA4 clears play_valid.
  - 0xA0 rewinds axi_araddr to 0.
  - Any other byte is ignored.
- channel1_wready passes through a 2-flop synchronizer; wready_s is the second flop output.
- States (one-hot, 3 bits): IDLE, AXI_ARADDR, AXI_RDATA.
- IDLE, burst issue:
  - Condition: play_valid & wready_s & (araddr + addr_step <= record_end_addr).
  - Compare is done at CTRL_ADDR_WIDTH+1 bits so the sum does not wrap.
  - When met: next state AXI_ARADDR, and axi_arvalid=1 on the same edge.
- IDLE, end of data:
  - Condition: play_valid & (araddr + addr_step > record_end_addr).
  - Action: clear play_valid, pulse play_done for exactly 1 cycle, no AR issued.
  - A partial final burst is never read.
- AXI_ARADDR:
  - arvalid stays high and araddr stays stable until arvalid & arready.
  - On that edge: arvalid=0, araddr += addr_step, state AXI_RDATA, beat_cnt=0.
- AXI_RDATA:
  - channel1_wr_en = axi_rvalid (combinational); channel1_data = axi_rdata.
  - beat_cnt increments per valid beat.
  - On rvalid & rlast: state IDLE. If beat_cnt != BURST_LEN-1 at that beat, set rd_err (cleared only by rst).
- Outside AXI_RDATA: channel1_wr_en=0; rvalid/rlast are ignored.
- Stop (0xA4) mid-burst:
  - play_valid clears immediately.
  - The outstanding AR/burst completes and all beats are still written to the FIFO.
  - FSM then rests in IDLE.
- Rewind (0xA0):
  - Takes priority over the araddr increment in the same cycle.
  - If issued while arvalid is high, the pending AR is not altered (address stable rule); the rewind is applied on the handshake edge instead of the increment.
  - Subsequent bursts start at 0.
- Simultaneous 0xA3 with end-of-data is not possible (one byte per strobe). Play with record_end_addr < addr_step ends immediately with play_done after 1 cycle in IDLE.
- Maximum back-to-back rate: the AR for burst N+1 is issued no earlier than 1 cycle after rlast of burst N (no outstanding-AR overlap).

Test Plan:
1. Reset, record_end_addr=512, wready=1, send 0xA3; arready/rvalid always high → 4 ARs at araddr 0,128,256,384, 64 wr_en beats equal to rdata, then play_done pulses once, play_valid=0, araddr=512.
2. wready held 0 for 20 cycles after 0xA3 → no arvalid; raising wready → arvalid within 3 cycles (2 sync + 1).
3. 0xA4 sent on beat 5 of a burst → remaining 11 beats still produce wr_en, rlast returns FSM to IDLE, no further arvalid.
4. 0xA0 sent while arvalid high with arready=0 for 10 cycles → araddr holds 128 until handshake, then becomes 0; the next burst reads address 0.
5. record_end_addr=100 + 0xA3 → zero arvalid, play_done 1-cycle pulse, play_valid=0; rlast asserted on beat 8 of a 16-beat burst → rd_err=1 and stays 1.
6. rst asserted mid-AXI_RDATA → all outputs reach reset values asynchronously; stray rvalid afterward gives wr_en=0.
